pipe_out_block_buffer: RTL and testbench
========================================

# pipe_out_block_buffer

Block-throttled output buffer between a word source (for example a pattern generator or a capture path) and an okBTPipeOut endpoint on okClk. It stores 32-bit words in a circular buffer and raises `pipe_out_ready` only when a full transfer block can be served. It tracks the host's in-progress block so that ready never over-commits. Sticky status flags report host reads on an empty buffer and block-protocol violations for readback via okWireOut.

## Interface
- `DEPTH_LOG2`, 10 — buffer depth is 2^DEPTH_LOG2 words. Must be at least log2(BLOCK_WORDS)+1.
- `BLOCK_WORDS`, 256 — words per BT pipe block (block size in bytes / 4). Power of two, at most 2^(DEPTH_LOG2-1).
- `clk` in 1 — okClk domain, the only clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `flush` in 1 — synchronous clear (wired from an okWireIn bit).
- `src_valid` in 1 — upstream word present.
- `src_data` in 32 — upstream word.
- `src_ready` out 1 — buffer can accept a word.
- `pipe_out_read` in 1 — okBTPipeOut ep_read.
- `pipe_out_blockstrobe` in 1 — okBTPipeOut ep_blockstrobe, one-cycle pulse at the start of each block.
- `pipe_out_data` out 32 — okBTPipeOut ep_datain.
- `pipe_out_ready` out 1 — okBTPipeOut ep_ready.
- `level` out DEPTH_LOG2+1 — words currently stored.
- `underrun` out 1 — sticky flag: a read occurred while the buffer was empty.
- `protocol_error` out 1 — sticky flag: a block protocol violation occurred.

## Operation
- Storage is a simple dual-port RAM with write pointer `wptr` and read pointer `rptr`, each DEPTH_LOG2 bits wide and wrapping modulo 2^DEPTH_LOG2.
- **Push**
  - Occurs when `src_valid & src_ready`: writes `src_data` at `wptr`, then `wptr` increments.
  - `src_ready = (level != 2^DEPTH_LOG2)`, driven combinationally from registered `level`.
- **Pop**
  - Occurs when `pipe_out_read & (level != 0)`: the RAM word at `rptr` is registered into `pipe_out_data`, then `rptr` increments.
- **Read when empty**
  - Occurs when `pipe_out_read & (level == 0)`.
  - `pipe_out_data` is loaded with 32'h0000_0000; pointers are unchanged; `underrun` is set.
- **level**
  - Push only: +1. Pop only: -1. Push and pop in the same cycle: unchanged.
  - Width DEPTH_LOG2+1, so a full buffer is representable and `level` never wraps.
- **Block tracking**
  - Counter `remaining` has width log2(BLOCK_WORDS)+1.
  - On `pipe_out_blockstrobe`, `remaining` loads BLOCK_WORDS. If `remaining != 0` at that moment, `protocol_error` is set and the counter still reloads.
  - Each read (pop or empty read) with `remaining != 0` decrements `remaining`.
  - A read with `remaining == 0` sets `protocol_error`. A read on the same cycle as the strobe counts against the new block, so `remaining` loads BLOCK_WORDS-1.
- **Ready**
  - `avail = level_next - remaining_next`, computed at full width. `level_next` and `remaining_next` are the values being loaded this cycle.
  - If `avail` is negative, it is treated as 0.
  - `pipe_out_ready` is registered as `avail >= BLOCK_WORDS`.
- **flush**
  - Single cycle; overrides push, pop and strobe in that cycle.
  - Pointers, `level` and `remaining` go to 0; `underrun`, `protocol_error`, `pipe_out_data` and `pipe_out_ready` go to 0.
- **Reset**
  - Asynchronous assertion of `reset_n` forces the same state as flush, including mid-block. RAM contents are don't-care.

## Timing
- Reset values: `pipe_out_data` = 0, `pipe_out_ready` = 0, `level` = 0, `underrun` = 0, `protocol_error` = 0. `src_ready` = 1, since it is derived from `level`.
- A word pushed at edge k can be popped at edge k+1 at the earliest.
- `pipe_out_data` is valid in the cycle after the edge that sampled `pipe_out_read`. This is the ep_read to ep_datain latency required by okBTPipeOut.
- `pipe_out_ready` reflects the state after the current edge, with one register of latency.
  - It rises on the edge that brings `avail` to BLOCK_WORDS.
  - It falls on the blockstrobe edge if fewer than 2×BLOCK_WORDS words are stored.
- `level`, `underrun` and `protocol_error` update on the same edge as the event that causes them.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- **Fill to first block.** Reset with DEPTH_LOG2=10, BLOCK_WORDS=256, then push 0,1,2,…
  - After 255 pushes: `pipe_out_ready` = 0.
  - On the 256th push edge: `pipe_out_ready` = 1, `level` = 256.
- **Block read with concurrent push.** Hold 512 words, strobe, then 256 back-to-back reads while pushing one word per cycle.
  - Data arrives 0..255 in order, each one cycle after its read.
  - `level` stays 512; `pipe_out_ready` stays 1; no flags are set.
- **Full buffer.** Push 1024 words.
  - `src_ready` drops when `level` = 1024.
  - After one read, `src_ready` = 1 and the next push is accepted; pointers wrap correctly (word 1024 follows word 1023).
- **Underrun.** From empty, strobe then read once.
  - `pipe_out_data` = 0; `underrun` = 1; `level` = 0; `remaining` = 255.
- **Protocol errors.** Strobe, read 100 words, strobe again → `protocol_error` = 1. Separately, read 257 words after one strobe → `protocol_error` = 1.
- **Flush and reset mid-block.** Flush with 300 words stored and `remaining` = 50.
  - Next cycle: `level` = 0, `pipe_out_ready` = 0, flags = 0.
  - Repeat with `reset_n` low mid-block → identical result.

Source files
------------

// File: rtl/pipe_out_block_buffer_if.sv
// Handshake bundle between a word source, the block buffer and an okBTPipeOut endpoint.
// master drives words and host reads; slave is the buffer itself.
interface pipe_out_block_buffer_if;
   logic        src_valid;
   logic [31:0] src_data;
   logic        src_ready;
   logic        pipe_out_read;
   logic        pipe_out_blockstrobe;
   logic [31:0] pipe_out_data;
   logic        pipe_out_ready;

   modport master (
      output src_valid, src_data, pipe_out_read, pipe_out_blockstrobe,
      input  src_ready, pipe_out_data, pipe_out_ready
   );

   modport slave (
      input  src_valid, src_data, pipe_out_read, pipe_out_blockstrobe,
      output src_ready, pipe_out_data, pipe_out_ready
   );
endinterface

// File: rtl/pipe_out_block_buffer.sv
// Circular word buffer feeding okBTPipeOut; ready is raised only when a whole block
// beyond the host's in-progress block is stored. Sticky underrun/protocol flags.
module pipe_out_block_buffer #(
   parameter int DEPTH_LOG2  = 10,
   parameter int BLOCK_WORDS = 256
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   pipe_out_block_buffer_if.slave   bus,
   output logic [DEPTH_LOG2:0]      level,
   output logic                     underrun,
   output logic                     protocol_error
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LVL_W = DEPTH_LOG2 + 1;
   localparam int REM_W = $clog2(BLOCK_WORDS) + 1;
   localparam int AV_W  = LVL_W + 1;

   localparam logic [LVL_W-1:0]      FULL_LEVEL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]      LVL_ONE    = LVL_W'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
   localparam logic [REM_W-1:0]      REM_ONE    = REM_W'(1);
   localparam logic [REM_W-1:0]      BLOCK_REM  = REM_W'(BLOCK_WORDS);
   localparam logic [AV_W-1:0]       BLOCK_AV   = AV_W'(BLOCK_WORDS);

   logic [31:0] mem [DEPTH];

   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [REM_W-1:0]      remaining_q, remaining_d;
   logic [31:0]           data_q, data_d;
   logic                  ready_q, ready_d;
   logic                  underrun_q, underrun_d;
   logic                  perr_q, perr_d;

   logic            space;
   logic            push;
   logic            pop;
   logic            rd_empty;
   logic [AV_W-1:0] avail;

   assign space = (level_q != FULL_LEVEL);

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      level_d     = level_q;
      remaining_d = remaining_q;
      data_d      = data_q;
      ready_d     = ready_q;
      underrun_d  = underrun_q;
      perr_d      = perr_q;
      push        = bus.src_valid && space && !flush;
      pop         = bus.pipe_out_read && (level_q != '0) && !flush;
      rd_empty    = bus.pipe_out_read && (level_q == '0) && !flush;
      avail       = '0;

      if (push) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (pop) begin
         rptr_d = rptr_q + PTR_ONE;
         data_d = mem[rptr_q];
      end
      if (rd_empty) begin
         data_d     = '0;
         underrun_d = 1'b1;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      // A read coinciding with the strobe belongs to the block being opened.
      if (bus.pipe_out_blockstrobe && !flush) begin
         if (remaining_q != '0) begin
            perr_d = 1'b1;
         end
         remaining_d = bus.pipe_out_read ? (BLOCK_REM - REM_ONE) : BLOCK_REM;
      end else if (bus.pipe_out_read && !flush) begin
         if (remaining_q != '0) begin
            remaining_d = remaining_q - REM_ONE;
         end else begin
            perr_d = 1'b1;
         end
      end

      // Words still owed to the current block are not available to a new one.
      avail   = {1'b0, level_d} - AV_W'(remaining_d);
      ready_d = !avail[AV_W-1] && (avail >= BLOCK_AV);

      if (flush) begin
         wptr_d      = '0;
         rptr_d      = '0;
         level_d     = '0;
         remaining_d = '0;
         data_d      = '0;
         ready_d     = 1'b0;
         underrun_d  = 1'b0;
         perr_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr_q] <= bus.src_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         remaining_q <= '0;
         data_q      <= '0;
         ready_q     <= 1'b0;
         underrun_q  <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         level_q     <= level_d;
         remaining_q <= remaining_d;
         data_q      <= data_d;
         ready_q     <= ready_d;
         underrun_q  <= underrun_d;
         perr_q      <= perr_d;
      end
   end

   assign bus.src_ready      = space;
   assign bus.pipe_out_data  = data_q;
   assign bus.pipe_out_ready = ready_q;
   assign level              = level_q;
   assign underrun           = underrun_q;
   assign protocol_error     = perr_q;

endmodule

// File: tb/tb_pipe_out_block_buffer.sv
// Directed bench for pipe_out_block_buffer with DEPTH_LOG2=10, BLOCK_WORDS=256.
// Expected values are hand-derived from the block-throttling behaviour.
module tb_pipe_out_block_buffer;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic [10:0] level;
   logic        underrun;
   logic        protocol_error;

   int vectorCount;
   int missCount;

   pipe_out_block_buffer_if bus ();

   pipe_out_block_buffer #(
      .DEPTH_LOG2  (10),
      .BLOCK_WORDS (256)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .flush          (flush),
      .bus            (bus),
      .level          (level),
      .underrun       (underrun),
      .protocol_error (protocol_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
      end
   endtask

   // One clock of stimulus; outputs are sampled 1 time unit after the edge.
   task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic rd,
                                input logic strobe, input logic fl);
      bus.src_valid            = valid;
      bus.src_data             = data;
      bus.pipe_out_read        = rd;
      bus.pipe_out_blockstrobe = strobe;
      flush                    = fl;
      @(posedge clk);
      #1;
      bus.src_valid            = 1'b0;
      bus.src_data             = '0;
      bus.pipe_out_read        = 1'b0;
      bus.pipe_out_blockstrobe = 1'b0;
      flush                    = 1'b0;
   endtask

   task automatic pushRange(input int first, input int count);
      for (int i = 0; i < count; i++) begin
         applyStimulus(1'b1, 32'(first + i), 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic readRange(input string tag, input int first, input int count);
      for (int i = 0; i < count; i++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
         checkOutput(tag, bus.pipe_out_data, 32'(first + i));
      end
   endtask

   task automatic checkCleared(input string tag);
      checkOutput({tag, "_level"}, 32'(level), 32'd0);
      checkOutput({tag, "_ready"}, 32'(bus.pipe_out_ready), 32'd0);
      checkOutput({tag, "_data"}, bus.pipe_out_data, 32'd0);
      checkOutput({tag, "_underrun"}, 32'(underrun), 32'd0);
      checkOutput({tag, "_perr"}, 32'(protocol_error), 32'd0);
      checkOutput({tag, "_srcready"}, 32'(bus.src_ready), 32'd1);
      checkOutput({tag, "_remaining"}, 32'(dut.remaining_q), 32'd0);
   endtask

   initial begin
      vectorCount              = 0;
      missCount                = 0;
      reset_n                  = 1'b0;
      flush                    = 1'b0;
      bus.src_valid            = 1'b0;
      bus.src_data             = '0;
      bus.pipe_out_read        = 1'b0;
      bus.pipe_out_blockstrobe = 1'b0;
      #2;
      checkCleared("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Fill to the first block
      pushRange(0, 255);
      checkOutput("fill255_ready", 32'(bus.pipe_out_ready), 32'd0);
      checkOutput("fill255_level", 32'(level), 32'd255);
      pushRange(255, 1);
      checkOutput("fill256_ready", 32'(bus.pipe_out_ready), 32'd1);
      checkOutput("fill256_level", 32'(level), 32'd256);

      // Block read with a concurrent push every cycle
      pushRange(256, 256);
      checkOutput("hold512_level", 32'(level), 32'd512);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("strobe512_ready", 32'(bus.pipe_out_ready), 32'd1);
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 32'(512 + i), 1'b1, 1'b0, 1'b0);
         checkOutput("blk_data", bus.pipe_out_data, 32'(i));
      end
      checkOutput("blk_level", 32'(level), 32'd512);
      checkOutput("blk_ready", 32'(bus.pipe_out_ready), 32'd1);
      checkOutput("blk_underrun", 32'(underrun), 32'd0);
      checkOutput("blk_perr", 32'(protocol_error), 32'd0);

      // Full buffer and pointer wrap
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checkCleared("flush1");
      pushRange(0, 1024);
      checkOutput("full_level", 32'(level), 32'd1024);
      checkOutput("full_srcready", 32'(bus.src_ready), 32'd0);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      checkOutput("full_reject_level", 32'(level), 32'd1024);
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
      checkOutput("full_rd0_data", bus.pipe_out_data, 32'd0);
      checkOutput("full_rd0_level", 32'(level), 32'd1023);
      checkOutput("full_rd0_srcready", 32'(bus.src_ready), 32'd1);
      applyStimulus(1'b1, 32'd1024, 1'b0, 1'b0, 1'b0);
      checkOutput("wrap_push_level", 32'(level), 32'd1024);
      for (int n = 1; n <= 1024; n++) begin
         applyStimulus(1'b0, '0, 1'b1, ((n % 256) == 0), 1'b0);
         checkOutput("wrap_data", bus.pipe_out_data, 32'(n));
      end
      checkOutput("wrap_level", 32'(level), 32'd0);
      checkOutput("wrap_perr", 32'(protocol_error), 32'd0);
      checkOutput("wrap_underrun", 32'(underrun), 32'd0);

      // Earliest pop, then underrun
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("early_pop_data", bus.pipe_out_data, 32'hA5A5_0001);
      checkOutput("early_pop_rem", 32'(dut.remaining_q), 32'd255);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("udr_data", bus.pipe_out_data, 32'd0);
      checkOutput("udr_flag", 32'(underrun), 32'd1);
      checkOutput("udr_level", 32'(level), 32'd0);
      checkOutput("udr_rem", 32'(dut.remaining_q), 32'd254);
      checkOutput("udr_perr", 32'(protocol_error), 32'd0);

      // Protocol error: early strobe; ready drops at strobe with < 2 blocks stored
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checkOutput("flush2_underrun", 32'(underrun), 32'd0);
      pushRange(0, 300);
      checkOutput("p1_ready_pre", 32'(bus.pipe_out_ready), 32'd1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("p1_ready_strobe", 32'(bus.pipe_out_ready), 32'd0);
      readRange("p1_data", 0, 100);
      checkOutput("p1_perr_pre", 32'(protocol_error), 32'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("p1_perr", 32'(protocol_error), 32'd1);
      checkOutput("p1_rem", 32'(dut.remaining_q), 32'd256);

      // Protocol error: overlong block
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checkOutput("flush3_perr", 32'(protocol_error), 32'd0);
      pushRange(0, 300);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      readRange("p2_data", 0, 256);
      checkOutput("p2_perr_pre", 32'(protocol_error), 32'd0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("p2_data257", bus.pipe_out_data, 32'd256);
      checkOutput("p2_perr", 32'(protocol_error), 32'd1);
      checkOutput("p2_rem", 32'(dut.remaining_q), 32'd0);
      checkOutput("p2_level", 32'(level), 32'd43);

      // Flush mid-block
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      pushRange(0, 506);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      readRange("mid_data", 0, 206);
      checkOutput("mid_level", 32'(level), 32'd300);
      checkOutput("mid_rem", 32'(dut.remaining_q), 32'd50);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checkCleared("flush_mid");

      // Asynchronous reset mid-block with ready and protocol_error set
      pushRange(0, 700);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      readRange("rst_data_a", 0, 100);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      readRange("rst_data_b", 100, 206);
      checkOutput("rst_pre_level", 32'(level), 32'd394);
      checkOutput("rst_pre_rem", 32'(dut.remaining_q), 32'd50);
      checkOutput("rst_pre_ready", 32'(bus.pipe_out_ready), 32'd1);
      checkOutput("rst_pre_perr", 32'(protocol_error), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkCleared("rst_async");
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkCleared("rst_after");

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
